rr_arbiter64: RTL and testbench
===============================

# rr_arbiter64

Round-robin arbiter sharing one downstream resource among 64 requesters. A priority-encoder core picks the highest-index active request inside a rotating mask. The grant is held until the winner releases it, drops its request, or exceeds a hold limit. It sits between the request lines of 64 clients and a single shared port, and drives one-hot and encoded grant outputs.

## Interface
- `N`, 64: number of requesters; must be a power of two, at least 2.
- `IDW`, `$clog2(N)` = 6: width of the grant index.
- `MAX_HOLD`, 16: maximum number of grant cycles per transaction; 0 disables the timeout.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N: per-requester request level; bit i is requester i.
- `rel` in 1: single-cycle release pulse from the current grantee.
- `gnt` out N: one-hot grant, registered.
- `gnt_id` out IDW: encoded index of the grantee; valid only while `gnt_valid` is 1.
- `gnt_valid` out 1: 1 while a grant is held.
- `timeout` out 1: single-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- Reset values: state IDLE, `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, pointer `ptr`=0, hold counter=0.
- Priority within a mask: the highest index wins, matching the codebase encoder convention.
- Mask: `mask = (1<<ptr)-1`.
  - Winner is the highest set bit of `req & mask` if that value is non-zero.
  - Otherwise the winner is the highest set bit of `req`.
  - With `ptr`=0 the mask is empty, so plain fixed priority applies.
- FSM IDLE:
  - If `req`≠0, register the winner into `gnt`/`gnt_id`, set `gnt_valid`=1, set `ptr`=winner, load counter=1, and go to BUSY.
  - If `req`=0, stay in IDLE with no state change.
- FSM BUSY, end-of-grant events, in priority order:
  - (1) `rel`=1.
  - (2) `req[gnt_id]`=0; a dropped request is treated as a release.
  - (3) `MAX_HOLD`≠0 and counter==`MAX_HOLD`. This is a timeout: assert `timeout` for 1 cycle.
  - Any of these clears the grant next cycle and returns to IDLE.
  - If none occurs, increment the counter (saturating) and hold `gnt`.
- `rel` together with the timeout condition counts as a release, and `timeout` stays 0.
- `rel` while IDLE is ignored.
- Requests other than the grantee's have no effect during BUSY.
- After a grant to index k, index k is excluded from the next arbitration if any lower index is requesting. Wrap-around: when no index below k requests, the unmasked highest request wins, which may be k itself.
- Reset asserted mid-grant: all outputs clear immediately (asynchronously) and `ptr` returns to 0.

## Timing
- Grant latency: `req` seen in IDLE at edge t gives `gnt_valid`=1 after edge t; one cycle, fully registered.
- Release to deassert: `rel` sampled at edge t gives `gnt`=0 after edge t.
- Back-to-back grants: there is a mandatory one-cycle IDLE gap. Release at t gives the next grant after edge t+1.
- Timeout: with `MAX_HOLD`=M, the grant is held exactly M cycles. `timeout` is high in the first cycle after the grant drops, coincident with `gnt_valid`=0.
- No combinational path from inputs to outputs.

## Structure
- Shared package `arb_pkg` holds:
  - the state enum `{IDLE, BUSY}`;
  - the constant `ARB_N`=64;
  - `ARB_IDW` = `$clog2(ARB_N)`;
  - the function `onehot(id)`.
- Sub-module `prio_enc_n`: a parameterised combinational highest-set-bit encoder with inputs `in[N]`, outputs `out[IDW]` and `any`. Instantiate it twice, once for the masked vector and once for the unmasked vector.
- The top level holds the FSM, `ptr`, the hold counter and the output registers.

## Test plan
- Fixed start: after reset, `req`=0x8000_0000_0000_0001 → `gnt_id`=63 one cycle later. Then `rel` → `gnt_id`=0 two cycles after `rel`.
- Rotation: `req`=all ones held, `rel` pulsed every grant → `gnt_id` sequence 63, 62, 61, …, 0, 63.
- Wrap / sole requester: `req`=0x10 only, repeated releases → `gnt_id`=4 every time, with a one-cycle gap between grants.
- Timeout: `MAX_HOLD`=16, `req[5]` held, no `rel` → `gnt_valid` high exactly 16 cycles, then a 1-cycle `timeout`. Repeat with `rel` on cycle 16 → `timeout`=0.
- Request drop: grantee 9 deasserts `req[9]` mid-grant → `gnt` clears next cycle, `timeout`=0, and next winner is the highest requester below 9.
- Reset mid-grant: `rst_n` low while BUSY → `gnt`, `gnt_valid`, `gnt_id` go to 0 without a clock. After release of reset with all ones requesting → `gnt_id`=63.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter types, sizing constants and helpers.
package arb_pkg;

  localparam int unsigned ARB_N   = 64;
  localparam int unsigned ARB_IDW = $clog2(ARB_N);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot vector with only bit id set.
  function automatic logic [ARB_N-1:0] onehot(input logic [ARB_IDW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-set-bit encoder.
module prio_enc_n #(
  parameter int unsigned N   = 64,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   in,
  output logic [IDW-1:0] out,
  output logic           any
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    out = '0;
    any = |in;
    for (int i = 0; i < N; i++) begin
      if (in[i]) out = IDW'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter64.sv
// Round-robin arbiter for 64 requesters with grant hold and hold-limit timeout.
module rr_arbiter64
  import arb_pkg::*;
#(
  parameter int unsigned N        = ARB_N,
  parameter int unsigned IDW      = $clog2(N),
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           rel,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int unsigned CW       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   gnt_d;
  logic [IDW-1:0] gnt_id_d;
  logic           gnt_valid_d;
  logic           timeout_d;

  logic [N-1:0]   mask;
  logic [N-1:0]   req_m;
  logic [IDW-1:0] id_m, id_u, win_id;
  logic           any_m, any_u;
  logic           hold_hit;
  logic           own_req;

  // Requesters strictly below the last winner get first chance.
  assign mask   = (N'(1) << ptr_q) - N'(1);
  assign req_m  = req & mask;
  assign win_id = any_m ? id_m : id_u;

  assign own_req  = req[gnt_id];
  assign hold_hit = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);

  prio_enc_n #(.N(N), .IDW(IDW)) u_enc_masked (
    .in  (req_m),
    .out (id_m),
    .any (any_m)
  );

  prio_enc_n #(.N(N), .IDW(IDW)) u_enc_full (
    .in  (req),
    .out (id_u),
    .any (any_u)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt;
    gnt_id_d    = gnt_id;
    gnt_valid_d = gnt_valid;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_u) begin
          state_d     = BUSY;
          gnt_d       = N'(onehot(ARB_IDW'(win_id)));
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          ptr_d       = win_id;
          cnt_d       = CW'(1);
        end
      end
      BUSY: begin
        if (rel || !own_req || hold_hit) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
          timeout_d   = hold_hit && !rel && own_req;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      gnt_id    <= gnt_id_d;
      gnt_valid <= gnt_valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter64.sv
// Scoreboard bench for rr_arbiter64 against a search-based reference model.
module tb_rr_arbiter64;

  localparam int N  = 64;
  localparam int MH = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req   = '0;
  logic          rel   = 1'b0;
  logic [N-1:0]  gnt;
  logic [5:0]    gnt_id;
  logic          gnt_valid;
  logic          timeout;

  rr_arbiter64 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int id;
    bit to;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   run   = 0;

  // Reference model: grant owner, hold length, last winner.
  bit m_busy = 0;
  int m_id   = 0;
  int m_hold = 0;
  int m_last = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Below the last winner first (descending), else the highest requester overall.
  function automatic int pick(input logic [63:0] r, input int last);
    for (int i = last - 1; i >= 0; i--) if (r[i]) return i;
    for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic [63:0] r, input bit rl);
    exp_t e;
    e.to = 0;
    if (!m_busy) begin
      if (r != 0) begin
        m_id   = pick(r, m_last);
        m_last = m_id;
        m_busy = 1;
        m_hold = 1;
      end
    end else if (rl || !r[m_id]) begin
      m_busy = 0;
    end else if (m_hold == MH) begin
      m_busy = 0;
      e.to   = 1;
    end else begin
      m_hold++;
    end
    e.v  = m_busy;
    e.id = m_id;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [63:0] r, input bit rl);
    req = r;
    rel = rl;
    @(posedge clk);
    model_edge(r, rl);
    run = 1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    run = 0;
    sbq.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", 64'(gnt_valid), 0);
    chk("rst_id", 64'(gnt_id), 0);
    chk("rst_timeout", 64'(timeout), 0);
    req = '0;
    rel = 1'b0;
    m_busy = 0; m_id = 0; m_hold = 0; m_last = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: one expectation per cycle, compared at the falling edge.
  always @(negedge clk) begin
    if (run) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got no expectation want one at %0t", $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("valid", 64'(gnt_valid), 64'(mon_e.v));
        chk("timeout", 64'(timeout), 64'(mon_e.to));
        chk("gnt", gnt, mon_e.v ? (64'(1) << mon_e.id) : 64'(0));
        if (mon_e.v) chk("gnt_id", 64'(gnt_id), 64'(mon_e.id));
      end
    end
  end

  logic [63:0] rr;
  bit          rl;

  initial begin
    do_reset();

    // Fixed start, then masked winner after release
    step(64'h8000_0000_0000_0001, 0);
    chk("fix_63", 64'(gnt_id), 63);
    step(64'h8000_0000_0000_0001, 1);
    chk("fix_rel", 64'(gnt_valid), 0);
    step(64'h8000_0000_0000_0001, 0);
    chk("fix_0", 64'(gnt_id), 0);
    step(64'h8000_0000_0000_0001, 1);

    // Rotation with all requesting
    do_reset();
    for (int k = 0; k <= 64; k++) begin
      step('1, 0);
      chk("rot_id", 64'(gnt_id), 64'((63 - k + 64) % 64));
      step('1, 1);
    end

    // Sole requester wraps onto itself, with an idle gap each time
    for (int k = 0; k < 4; k++) begin
      step(64'h10, 0);
      chk("sole_id", 64'(gnt_id), 4);
      step(64'h10, 1);
      chk("sole_gap", 64'(gnt_valid), 0);
    end

    // Timeout after exactly MH cycles, then release on cycle MH suppresses it
    do_reset();
    step(64'h20, 0);
    repeat (MH - 1) step(64'h20, 0);
    chk("to_held", 64'(gnt_valid), 1);
    step(64'h20, 0);
    chk("to_pulse", 64'(timeout), 1);
    chk("to_drop", 64'(gnt_valid), 0);
    step(64'h20, 0);
    chk("to_clear", 64'(timeout), 0);
    repeat (MH - 1) step(64'h20, 0);
    step(64'h20, 1);
    chk("relto_timeout", 64'(timeout), 0);
    chk("relto_valid", 64'(gnt_valid), 0);

    // Grantee drops its request
    do_reset();
    step(64'h20A, 0);
    chk("drop_9", 64'(gnt_id), 9);
    step(64'h20A, 0);
    step(64'h00A, 0);
    chk("drop_clear", 64'(gnt_valid), 0);
    chk("drop_noto", 64'(timeout), 0);
    step(64'h00A, 0);
    chk("drop_next", 64'(gnt_id), 3);

    // Randomized traffic with slowly changing requests
    rr = {$urandom, $urandom};
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: rr = '0;
          1: rr = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
          2: rr = 64'(1) << $urandom_range(63);
          default: rr = {$urandom, $urandom};
        endcase
      end
      rl = ($urandom_range(9) == 0);
      step(rr, rl);
    end

    // Asynchronous reset mid-grant, then fresh fixed priority
    do_reset();
    step('1, 0);
    step('1, 0);
    chk("mid_busy", 64'(gnt_valid), 1);
    do_reset();
    step('1, 0);
    chk("post_rst_63", 64'(gnt_id), 63);
    step('1, 1);

    @(negedge clk);
    #1 run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
